// File: rtl/out_port_vc_alloc_pkg.sv
// Shared definitions for the output-port VC allocator: flit coding, buffer depth
// and the default sizing of one output port of a 5-port, 4-VC router.
package out_port_vc_alloc_pkg;

    localparam int VC_SIZE = 4;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    localparam int DEF_NUM_REQ    = 20;
    localparam int DEF_NUM_OVC    = 4;
    localparam int DEF_CREDIT_MAX = VC_SIZE;
    localparam int DEF_CREDIT_W   = 3;
    localparam int DEF_OVC_W      = 2;

endpackage

// File: rtl/out_port_vc_alloc_rr_arbiter.sv
// Combinational round-robin arbiter: first unmasked requester at or after ptr wins.
// The pointer register lives in the parent.
module out_port_vc_alloc_rr_arbiter #(
    parameter int N = 20
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 any
);

    localparam int PW = $clog2(N);

    logic [N-1:0] eff_s;

    function automatic logic [PW-1:0] wrap_idx(input int a);
        return PW'((a >= N) ? (a - N) : a);
    endfunction

    assign eff_s = req & ~mask;

    // scan from the pointer; only the first hit (while any is still low) is granted
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int off = 0; off < N; off++) begin
            gnt[wrap_idx(int'(ptr) + off)] = !any && eff_s[wrap_idx(int'(ptr) + off)];
            any = any | eff_s[wrap_idx(int'(ptr) + off)];
        end
    end

endmodule

// File: rtl/out_port_vc_alloc.sv
// Per-output-port OVC allocator with downstream credit tracking. Grants are
// registered one-cycle pulses; an OVC is reusable only once fully drained.
module out_port_vc_alloc
    import out_port_vc_alloc_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int NUM_OVC    = DEF_NUM_OVC,
    parameter int CREDIT_MAX = DEF_CREDIT_MAX,
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int OVC_W      = DEF_OVC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           grant,
    output logic [OVC_W-1:0]             grant_ovc,
    input  logic                         send_valid,
    input  logic [OVC_W-1:0]             send_ovc,
    input  logic                         send_tail,
    input  logic                         credit_valid,
    input  logic [OVC_W-1:0]             credit_ovc,
    output logic [NUM_OVC*CREDIT_W-1:0]  credit_cnt,
    output logic [NUM_OVC-1:0]           ovc_busy,
    output logic                         err
);

    localparam int                   PTR_W     = $clog2(NUM_REQ);
    localparam logic [CREDIT_W-1:0]  CRED_FULL = CREDIT_W'(CREDIT_MAX);
    localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]                   ptr_r, ptr_next_s;
    logic [NUM_REQ-1:0]                 grant_r, grant_next_s;
    logic [OVC_W-1:0]                   grant_ovc_r, grant_ovc_next_s;
    logic [NUM_OVC-1:0]                 busy_r, busy_next_s;
    logic [NUM_OVC-1:0][CREDIT_W-1:0]   credit_r, credit_next_s;
    logic                               err_r, err_next_s;

    logic [NUM_REQ-1:0]                 arb_gnt_s;
    logic                               arb_any_s;
    logic [NUM_OVC-1:0]                 elig_s;
    logic                               ovc_any_s;
    logic [OVC_W-1:0]                   ovc_sel_s;
    logic [PTR_W-1:0]                   win_idx_s;
    logic                               alloc_s;
    logic [NUM_OVC-1:0]                 rel_mask_s, alloc_mask_s;
    logic                               sat_err_s;

    // last cycle's winner is masked: its req is still high while it sees the grant
    out_port_vc_alloc_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req  (req),
        .mask (grant_r),
        .ptr  (ptr_r),
        .gnt  (arb_gnt_s),
        .any  (arb_any_s)
    );

    // lowest-index idle OVC whose downstream buffer is completely drained
    always_comb begin
        elig_s    = '0;
        ovc_any_s = 1'b0;
        ovc_sel_s = '0;
        for (int k = NUM_OVC - 1; k >= 0; k--) begin
            elig_s[k] = !busy_r[k] && (credit_r[k] == CRED_FULL);
            ovc_sel_s = elig_s[k] ? OVC_W'(k) : ovc_sel_s;
            ovc_any_s = ovc_any_s | elig_s[k];
        end
    end

    // one-hot winner to index, for the pointer update
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx_s = win_idx_s | (arb_gnt_s[i] ? PTR_W'(i) : '0);
        end
    end

    // allocation, release and pointer next state
    always_comb begin
        alloc_s          = arb_any_s && ovc_any_s;
        grant_next_s     = alloc_s ? arb_gnt_s : '0;
        grant_ovc_next_s = alloc_s ? ovc_sel_s : '0;
        alloc_mask_s     = alloc_s ? (NUM_OVC'(1) << ovc_sel_s) : '0;
        rel_mask_s       = (send_valid && send_tail) ? (NUM_OVC'(1) << send_ovc) : '0;
        busy_next_s      = (busy_r & ~rel_mask_s) | alloc_mask_s;
        if (alloc_s) begin
            ptr_next_s = (win_idx_s == PTR_LAST) ? '0 : (win_idx_s + PTR_W'(1));
        end else begin
            ptr_next_s = ptr_r;
        end
        err_next_s = err_r | sat_err_s | (send_valid && !busy_r[send_ovc]);
    end

    // per-OVC credit update; a send and a return on the same OVC cancel out
    always_comb begin
        credit_next_s = credit_r;
        sat_err_s     = 1'b0;
        for (int k = 0; k < NUM_OVC; k++) begin
            case ({send_valid && (send_ovc == OVC_W'(k)),
                   credit_valid && (credit_ovc == OVC_W'(k))})
                2'b10: begin
                    if (credit_r[k] == '0) begin
                        sat_err_s = 1'b1;
                    end else begin
                        credit_next_s[k] = credit_r[k] - CREDIT_W'(1);
                    end
                end
                2'b01: begin
                    if (credit_r[k] == CRED_FULL) begin
                        sat_err_s = 1'b1;
                    end else begin
                        credit_next_s[k] = credit_r[k] + CREDIT_W'(1);
                    end
                end
                default: credit_next_s[k] = credit_r[k];
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= '0;
            grant_r     <= '0;
            grant_ovc_r <= '0;
            busy_r      <= '0;
            credit_r    <= {NUM_OVC{CRED_FULL}};
            err_r       <= 1'b0;
        end else begin
            ptr_r       <= ptr_next_s;
            grant_r     <= grant_next_s;
            grant_ovc_r <= grant_ovc_next_s;
            busy_r      <= busy_next_s;
            credit_r    <= credit_next_s;
            err_r       <= err_next_s;
        end
    end

    assign grant      = grant_r;
    assign grant_ovc  = grant_ovc_r;
    assign ovc_busy   = busy_r;
    assign credit_cnt = credit_r;
    assign err        = err_r;

endmodule

// File: tb/tb_out_port_vc_alloc.sv
// Bench for out_port_vc_alloc: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the allocator.
module tb_out_port_vc_alloc;

    localparam int NR = 20;
    localparam int NO = 4;
    localparam int CM = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     grant;
    logic [1:0]        grant_ovc;
    logic              send_valid;
    logic [1:0]        send_ovc;
    logic              send_tail;
    logic              credit_valid;
    logic [1:0]        credit_ovc;
    logic [NO*CW-1:0]  credit_cnt;
    logic [NO-1:0]     ovc_busy;
    logic              err;

    always #5 clk = ~clk;

    out_port_vc_alloc dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .grant_ovc    (grant_ovc),
        .send_valid   (send_valid),
        .send_ovc     (send_ovc),
        .send_tail    (send_tail),
        .credit_valid (credit_valid),
        .credit_ovc   (credit_ovc),
        .credit_cnt   (credit_cnt),
        .ovc_busy     (ovc_busy),
        .err          (err)
    );

    // reference state: which OVCs are held, credits left, who was granted last
    bit            m_busy [NO];
    int            m_cred [NO];
    bit            m_err;
    int            m_ptr;
    int            m_last;
    logic [NR-1:0] m_grant;
    int            m_govc;
    logic [NR-1:0] drop_next;

    int n_checks = 0;
    int n_fail   = 0;
    int ri, rk, rk2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NO; k++) begin
            m_busy[k] = 1'b0;
            m_cred[k] = CM;
        end
        m_err   = 1'b0;
        m_ptr   = 0;
        m_last  = -1;
        m_grant = '0;
        m_govc  = 0;
    endfunction

    function automatic void model_step();
        int ovc = -1;
        int win = -1;
        for (int k = NO - 1; k >= 0; k--)
            if (!m_busy[k] && m_cred[k] == CM) ovc = k;
        for (int off = 0; off < NR; off++) begin
            int i;
            i = (m_ptr + off) % NR;
            if (win < 0 && req[i] && i != m_last) win = i;
        end
        if (send_valid && !m_busy[send_ovc]) m_err = 1'b1;
        if (send_valid && send_tail) m_busy[send_ovc] = 1'b0;
        if (win >= 0 && ovc >= 0) begin
            m_grant      = '0;
            m_grant[win] = 1'b1;
            m_govc       = ovc;
            m_busy[ovc]  = 1'b1;
            m_ptr        = (win + 1) % NR;
            m_last       = win;
        end else begin
            m_grant = '0;
            m_govc  = 0;
            m_last  = -1;
        end
        if (!(send_valid && credit_valid && send_ovc == credit_ovc)) begin
            if (send_valid) begin
                if (m_cred[send_ovc] == 0) m_err = 1'b1;
                else m_cred[send_ovc]--;
            end
            if (credit_valid) begin
                if (m_cred[credit_ovc] == CM) m_err = 1'b1;
                else m_cred[credit_ovc]++;
            end
        end
    endfunction

    task automatic compare_all();
        logic [63:0] b;
        logic [63:0] c;
        b = '0;
        c = '0;
        for (int k = 0; k < NO; k++) begin
            b[k] = m_busy[k];
            c = c | (64'(m_cred[k]) << (k * CW));
        end
        check("grant", 64'(grant), 64'(m_grant));
        check("grant_ovc", 64'(grant_ovc), 64'(m_govc));
        check("ovc_busy", 64'(ovc_busy), b);
        check("credit_cnt", 64'(credit_cnt), c);
        check("err", 64'(err), 64'(m_err));
    endtask

    // one clock: model follows the inputs the DUT sampled, then outputs are compared
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
        req       = req & ~drop_next;
        drop_next = m_grant;
    endtask

    initial begin
        rst = 1'b1; req = '0; drop_next = '0;
        send_valid = 1'b0; send_ovc = 2'd0; send_tail = 1'b0;
        credit_valid = 1'b0; credit_ovc = 2'd0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        check("reset_cnt", 64'(credit_cnt), 64'h924);
        check("reset_grant", 64'(grant), 64'h0);

        // single requester, then masked on its trailing cycle
        req[3] = 1'b1;
        tick();
        check("t1_grant", 64'(grant), 64'h8);
        check("t1_busy", 64'(ovc_busy), 64'h1);
        tick();
        check("t1_mask", 64'(grant), 64'h0);

        rst = 1'b1; tick(); rst = 1'b0;

        // round robin across 0,5,9; then pointer at 10 beats requester 0
        req = '0; req[0] = 1'b1; req[5] = 1'b1; req[9] = 1'b1;
        tick();
        check("t2_g0", 64'(grant), 64'h1);
        tick();
        check("t2_g5", 64'(grant), 64'h20);
        check("t2_ovc1", 64'(grant_ovc), 64'd1);
        tick();
        check("t2_g9", 64'(grant), 64'h200);
        check("t2_ovc2", 64'(grant_ovc), 64'd2);
        tick();
        req[0] = 1'b1; req[10] = 1'b1;
        tick();
        check("t2_ptr10", 64'(grant), 64'h400);
        check("t2_ovc3", 64'(grant_ovc), 64'd3);
        tick();
        req = '0;

        // all OVCs busy; OVC1 drains and is reused one cycle after refilling
        req[2] = 1'b1;
        tick(); tick();
        check("t3_wait", 64'(grant), 64'h0);
        send_valid = 1'b1; send_ovc = 2'd1;
        for (int n = 0; n < 4; n++) begin
            send_tail = (n == 3);
            tick();
        end
        send_valid = 1'b0; send_tail = 1'b0;
        credit_valid = 1'b1; credit_ovc = 2'd1;
        for (int n = 0; n < 4; n++) tick();
        credit_valid = 1'b0;
        check("t3_cnt1", 64'(credit_cnt[1*CW +: CW]), 64'd4);
        check("t3_nogrant", 64'(grant), 64'h0);
        tick();
        check("t3_grant", 64'(grant), 64'h4);
        check("t3_ovc", 64'(grant_ovc), 64'd1);
        tick();

        // drain OVC0 to zero, fifth send saturates and raises err
        send_valid = 1'b1; send_ovc = 2'd0;
        for (int n = 0; n < 4; n++) tick();
        check("t4_zero", 64'(credit_cnt[0 +: CW]), 64'd0);
        check("t4_noerr", 64'(err), 64'd0);
        tick();
        check("t4_sat", 64'(credit_cnt[0 +: CW]), 64'd0);
        check("t4_err", 64'(err), 64'd1);

        // simultaneous send and return, same and different OVCs
        send_ovc = 2'd2;
        tick();
        credit_valid = 1'b1; credit_ovc = 2'd2;
        tick();
        check("t5_same", 64'(credit_cnt[2*CW +: CW]), 64'd3);
        credit_valid = 1'b0; send_ovc = 2'd1;
        tick();
        credit_valid = 1'b1; credit_ovc = 2'd2;
        tick();
        check("t5_dec1", 64'(credit_cnt[1*CW +: CW]), 64'd2);
        check("t5_inc2", 64'(credit_cnt[2*CW +: CW]), 64'd4);
        send_valid = 1'b0; credit_valid = 1'b0;

        // reset in the middle of traffic
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", 64'(ovc_busy), 64'h0);
        check("t6_cnt", 64'(credit_cnt), 64'h924);
        check("t6_err", 64'(err), 64'h0);
        check("t6_grant", 64'(grant), 64'h0);

        // random traffic, legal most of the time
        for (int c = 0; c < 3000; c++) begin
            rst = (c % 500 == 499);
            if ($urandom_range(0, 2) == 0) begin
                ri = $urandom_range(0, NR - 1);
                if (!drop_next[ri]) req[ri] = 1'b1;
            end
            send_valid = 1'b0; send_tail = 1'b0;
            rk = $urandom_range(0, NO - 1);
            if (m_busy[rk] && m_cred[rk] > 0 && $urandom_range(0, 1) == 1) begin
                send_valid = 1'b1;
                send_ovc   = 2'(rk);
                send_tail  = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 299) == 0) begin
                send_valid = 1'b1;
                send_ovc   = 2'($urandom_range(0, NO - 1));
            end
            credit_valid = 1'b0;
            rk2 = $urandom_range(0, NO - 1);
            if (m_cred[rk2] < CM && $urandom_range(0, 1) == 1) begin
                credit_valid = 1'b1;
                credit_ovc   = 2'(rk2);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
